// File: rtl/player_pkg.sv
// Shared definitions for the maze player navigation block: heading encodings,
// PS/2 set-2 scancodes, decoded command and FSM state types, and the key decoder.
package player_pkg;

  localparam logic [1:0] DIR_E = 2'b00;
  localparam logic [1:0] DIR_N = 2'b01;
  localparam logic [1:0] DIR_W = 2'b10;
  localparam logic [1:0] DIR_S = 2'b11;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;

  typedef enum logic [2:0] {CMD_NONE, CMD_FWD, CMD_BACK, CMD_ROT_L, CMD_ROT_R} cmd_t;

  typedef enum logic [1:0] {IDLE, QUERY, COMMIT} nav_state_t;

  // Plain and E0-extended codes are separate key spaces: E0 1D is not W.
  function automatic cmd_t decode_key(input logic ext, input logic [7:0] code);
    cmd_t c;
    c = CMD_NONE;
    if (ext) begin
      case (code)
        SC_UP:    c = CMD_FWD;
        SC_DOWN:  c = CMD_BACK;
        SC_LEFT:  c = CMD_ROT_L;
        SC_RIGHT: c = CMD_ROT_R;
        default:  c = CMD_NONE;
      endcase
    end else begin
      case (code)
        SC_W:    c = CMD_FWD;
        SC_S:    c = CMD_BACK;
        SC_A:    c = CMD_ROT_L;
        SC_D:    c = CMD_ROT_R;
        default: c = CMD_NONE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ps2_key_cmd.sv
// PS/2 byte stream to navigation commands.
// Tracks E0/F0 prefixes, the currently held mapped key and its auto-repeat timer.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   scancode[7:0]         byte from the PS/2 controller
//   scancode_valid        one-cycle strobe qualifying scancode
//   cmd, cmd_valid        decoded command, valid for exactly one cycle
module ps2_key_cmd
  import player_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 6_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  output cmd_t       cmd,
  output logic       cmd_valid
);

  localparam int unsigned CntW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  logic            ext_q, brk_q;
  logic            held_valid_q, held_ext_q;
  logic [7:0]      held_code_q;
  logic [CntW-1:0] cnt_q;

  logic is_prefix, key_byte, held_match, make_new, brk_held, repeat_fire;
  cmd_t key_cmd, held_cmd;

  always_comb begin
    is_prefix   = (scancode == SC_E0) || (scancode == SC_F0);
    key_byte    = scancode_valid && !is_prefix;
    key_cmd     = decode_key(ext_q, scancode);
    held_cmd    = decode_key(held_ext_q, held_code_q);
    held_match  = held_valid_q && (held_ext_q == ext_q) && (held_code_q == scancode);
    // Typematic re-sends of the held key are swallowed here.
    make_new    = key_byte && !brk_q && (key_cmd != CMD_NONE) && !held_match;
    brk_held    = key_byte && brk_q && held_match;
    repeat_fire = held_valid_q && (cnt_q == CntW'(REPEAT_DELAY - 1)) && !brk_held;
    cmd_valid   = make_new || repeat_fire;
    cmd         = make_new ? key_cmd : (repeat_fire ? held_cmd : CMD_NONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      cnt_q        <= '0;
    end else begin
      if (scancode_valid) begin
        if (scancode == SC_E0) begin
          ext_q <= 1'b1;
        end else if (scancode == SC_F0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
      if (make_new) begin
        held_valid_q <= 1'b1;
        held_ext_q   <= ext_q;
        held_code_q  <= scancode;
        cnt_q        <= '0;
      end else if (brk_held) begin
        held_valid_q <= 1'b0;
        cnt_q        <= '0;
      end else if (held_valid_q) begin
        cnt_q <= repeat_fire ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_nav.sv
// Grid navigation controller for the maze player. Owns position and heading,
// turns keyboard commands into rotations or wall-checked single-tile moves.
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   scancode, scancode_valid   PS/2 byte stream
//   wall_req/x/y               tile lookup request, held with stable coords until wall_ack
//   wall_ack, wall_hit         lookup done; wall_hit qualified by wall_ack
//   x_position, y_position     current tile
//   dir                        heading 00=E 01=N 10=W 11=S
//   moved, bumped              one-cycle outcome pulses
//   busy                       high while a move lookup/commit is in flight
module player_nav
  import player_pkg::*;
#(
  parameter int unsigned MAP_W        = 20,
  parameter int unsigned MAP_H        = 20,
  parameter int unsigned COORD_W      = 5,
  parameter int unsigned REPEAT_DELAY = 6_000_000,
  parameter int unsigned START_X      = 1,
  parameter int unsigned START_Y      = 1,
  parameter logic [1:0]  START_DIR    = 2'b00
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         scancode,
  input  logic               scancode_valid,
  output logic               wall_req,
  output logic [COORD_W-1:0] wall_x,
  output logic [COORD_W-1:0] wall_y,
  input  logic               wall_ack,
  input  logic               wall_hit,
  output logic [COORD_W-1:0] x_position,
  output logic [COORD_W-1:0] y_position,
  output logic [1:0]         dir,
  output logic               moved,
  output logic               bumped,
  output logic               busy
);

  localparam logic [COORD_W:0] MapWExt = (COORD_W + 1)'(MAP_W);
  localparam logic [COORD_W:0] MapHExt = (COORD_W + 1)'(MAP_H);

  cmd_t key_cmd;
  logic key_valid;

  ps2_key_cmd #(
    .REPEAT_DELAY(REPEAT_DELAY)
  ) u_keys (
    .clock         (clock),
    .reset         (reset),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .cmd           (key_cmd),
    .cmd_valid     (key_valid)
  );

  // Single-entry command slot; a newer command overwrites an unserved one.
  cmd_t pend_cmd_q;
  logic pend_valid_q;
  nav_state_t state_q;
  logic pop;

  assign pop = pend_valid_q && (state_q == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_cmd_q   <= CMD_NONE;
      pend_valid_q <= 1'b0;
    end else if (key_valid) begin
      pend_cmd_q   <= key_cmd;
      pend_valid_q <= 1'b1;
    end else if (pop) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Target tile one step along the move heading. One extra bit so that 0-1
  // wraps to a large value and fails the bounds test like any other overrun.
  logic [1:0]       move_dir;
  logic [COORD_W:0] tgt_x, tgt_y;
  logic             tgt_oob;

  always_comb begin
    move_dir = (pend_cmd_q == CMD_BACK) ? (dir ^ 2'b10) : dir;
    tgt_x    = {1'b0, x_position};
    tgt_y    = {1'b0, y_position};
    case (move_dir)
      DIR_E:   tgt_x = {1'b0, x_position} + 1'b1;
      DIR_N:   tgt_y = {1'b0, y_position} - 1'b1;
      DIR_W:   tgt_x = {1'b0, x_position} - 1'b1;
      DIR_S:   tgt_y = {1'b0, y_position} + 1'b1;
      default: tgt_y = {1'b0, y_position};
    endcase
    tgt_oob = (tgt_x >= MapWExt) || (tgt_y >= MapHExt);
  end

  logic hit_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      x_position <= COORD_W'(START_X);
      y_position <= COORD_W'(START_Y);
      dir        <= START_DIR;
      wall_req   <= 1'b0;
      wall_x     <= '0;
      wall_y     <= '0;
      hit_q      <= 1'b0;
      moved      <= 1'b0;
      bumped     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      moved  <= 1'b0;
      bumped <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            case (pend_cmd_q)
              CMD_ROT_L: dir <= dir + 2'd1;
              CMD_ROT_R: dir <= dir - 2'd1;
              CMD_FWD, CMD_BACK: begin
                if (tgt_oob) begin
                  bumped <= 1'b1;
                end else begin
                  // Target is frozen here; later rotations cannot disturb it.
                  wall_x   <= tgt_x[COORD_W-1:0];
                  wall_y   <= tgt_y[COORD_W-1:0];
                  wall_req <= 1'b1;
                  busy     <= 1'b1;
                  state_q  <= QUERY;
                end
              end
              default: ;
            endcase
          end
        end
        QUERY: begin
          if (wall_ack) begin
            wall_req <= 1'b0;
            hit_q    <= wall_hit;
            state_q  <= COMMIT;
          end
        end
        COMMIT: begin
          if (hit_q) begin
            bumped <= 1'b1;
          end else begin
            x_position <= wall_x;
            y_position <= wall_y;
            moved      <= 1'b1;
          end
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_nav.sv
module tb_player_nav;

  localparam int RD = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scancode = 8'h00;
  logic       scancode_valid = 1'b0;
  logic       wall_req;
  logic [4:0] wall_x, wall_y;
  logic       wall_ack = 1'b0;
  logic       wall_hit = 1'b0;
  logic [4:0] x_position, y_position;
  logic [1:0] dir;
  logic       moved, bumped, busy;

  player_nav #(
    .MAP_W(20), .MAP_H(20), .COORD_W(5), .REPEAT_DELAY(RD),
    .START_X(1), .START_Y(1), .START_DIR(2'b00)
  ) dut (
    .clock(clock), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y), .wall_ack(wall_ack),
    .wall_hit(wall_hit), .x_position(x_position), .y_position(y_position), .dir(dir),
    .moved(moved), .bumped(bumped), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: tile grid, walls and heading as plain integers.
  typedef struct packed {
    logic [1:0] kind;  // 0 move, 1 bump, 2 rotation
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] d;
  } ev_t;

  ev_t        exp_q[$];
  logic [9:0] look_q[$];
  bit         wall_map [0:19][0:19];
  int mx = 1, my = 1, mdir = 0;

  logic [7:0] plain_codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
  logic [7:0] ext_codes   [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  // c: 1 FWD, 2 BACK, 3 ROT_L, 4 ROT_R
  task automatic model_cmd(input int c);
    int d, tx, ty;
    ev_t e;
    if (c == 3 || c == 4) begin
      mdir = (c == 3) ? (mdir + 1) % 4 : (mdir + 3) % 4;
      e = {2'd2, 5'(mx), 5'(my), 2'(mdir)};
      exp_q.push_back(e);
      return;
    end
    d  = (c == 1) ? mdir : (mdir + 2) % 4;
    tx = mx;
    ty = my;
    case (d)
      0: tx = tx + 1;
      1: ty = ty - 1;
      2: tx = tx - 1;
      default: ty = ty + 1;
    endcase
    if (tx < 0 || tx >= 20 || ty < 0 || ty >= 20) begin
      e = {2'd1, 5'(mx), 5'(my), 2'(mdir)};
    end else begin
      look_q.push_back({5'(tx), 5'(ty)});
      if (wall_map[ty][tx]) begin
        e = {2'd1, 5'(mx), 5'(my), 2'(mdir)};
      end else begin
        mx = tx;
        my = ty;
        e = {2'd0, 5'(mx), 5'(my), 2'(mdir)};
      end
    end
    exp_q.push_back(e);
  endtask

  // Wall lookup responder.
  bit auto_ack = 1'b0;
  int ack_lat = 0;
  int lat_cnt = 0;
  always @(posedge clock) begin
    #2;
    if (auto_ack) begin
      wall_ack = 1'b0;
      if (wall_req) begin
        if (lat_cnt == ack_lat) begin
          wall_ack = 1'b1;
          wall_hit = wall_map[wall_y][wall_x];
          lat_cnt  = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  bit         mon_en = 1'b0;
  logic       prev_req = 1'b0;
  logic [1:0] prev_dir = 2'b00;
  logic [9:0] req_xy;
  int req_len = 0, last_req_len = 0, req_rises = 0;
  int last_req_cyc = 0, last_moved_cyc = 0, last_bump_cyc = 0;
  int moved_total = 0, bumped_total = 0;
  int moved_cycs[$];
  ev_t act;

  always @(negedge clock) begin
    if (moved === 1'b1) begin
      moved_total++;
      last_moved_cyc = cyc;
      moved_cycs.push_back(cyc);
    end
    if (bumped === 1'b1) begin
      bumped_total++;
      last_bump_cyc = cyc;
    end
    if (wall_req === 1'b1 && !prev_req) begin
      req_rises++;
      last_req_cyc = cyc;
      req_len = 1;
      req_xy = {wall_x, wall_y};
      if (mon_en) begin
        if (look_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL lookup: got request at (%0d,%0d), expected none", wall_x, wall_y);
        end else begin
          check("lookup_xy", {wall_x, wall_y}, look_q.pop_front());
        end
      end
    end else if (wall_req === 1'b1) begin
      req_len++;
      check("lookup_xy_stable", {wall_x, wall_y}, req_xy);
    end else if (prev_req) begin
      last_req_len = req_len;
    end
    if (mon_en && (moved || bumped || dir !== prev_dir)) begin
      act = {moved ? 2'd0 : (bumped ? 2'd1 : 2'd2), x_position, y_position, dir};
      if (moved && bumped) check("moved_bumped_exclusive", {moved, bumped}, 2'b10);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL event: got 0x%0h, expected no event", act);
      end else begin
        check("event", act, exp_q.pop_front());
      end
    end
    prev_req = (wall_req === 1'b1);
    prev_dir = dir;
  end

  // Stimulus helpers.
  int sent_cyc = 0;

  task automatic send(input logic [7:0] b);
    @(posedge clock); #1;
    scancode = b;
    scancode_valid = 1'b1;
    sent_cyc = cyc;
    @(posedge clock); #1;
    scancode_valid = 1'b0;
  endtask

  task automatic send_at(input int c, input logic [7:0] b);
    while (cyc < c - 1) begin
      @(posedge clock); #1;
    end
    send(b);
  endtask

  // Press and release one key; mk returns the cycle of the make byte.
  task automatic tap(input int c, input bit ext, input bit dup, output int mk);
    logic [7:0] code;
    code = ext ? ext_codes[c-1] : plain_codes[c-1];
    model_cmd(c);
    if (ext) send(8'hE0);
    send(code);
    mk = sent_cyc;
    if (dup) begin
      if (ext) send(8'hE0);
      send(code);
    end
    if (ext) send(8'hE0);
    send(8'hF0);
    send(code);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || look_q.size() != 0 || busy) && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_settled"}, 32'(n < 300), 32'd1);
    if (n >= 300) begin
      exp_q.delete();
      look_q.delete();
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int mk, r0, p0, m0;

  initial begin
    for (int yy = 0; yy < 20; yy++)
      for (int xx = 0; xx < 20; xx++) wall_map[yy][xx] = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_x", x_position, 1);
    check("rst_y", y_position, 1);
    check("rst_dir", dir, 0);
    check("rst_wall_req", wall_req, 0);
    check("rst_moved", moved, 0);
    check("rst_bumped", bumped, 0);
    check("rst_busy", busy, 0);
    mon_en = 1'b1;

    // Step east with wall_ack tied high: zero-latency lookup.
    wall_ack = 1'b1;
    wall_hit = 1'b0;
    tap(1, 1'b0, 1'b0, mk);
    wait_idle("t1");
    check("t1_req_cycle", last_req_cyc, mk + 2);
    check("t1_moved_cycle", last_moved_cyc, mk + 4);
    check("t1_pos", {x_position, y_position}, {5'd2, 5'd1});
    wall_ack = 1'b0;
    auto_ack = 1'b1;
    ack_lat  = 0;

    // Rotations, extended then plain; no outcome pulses.
    p0 = moved_total + bumped_total;
    tap(3, 1'b1, 1'b0, mk);
    wait_idle("t2a");
    check("t2_dir_n", dir, 2'b01);
    tap(3, 1'b0, 1'b0, mk);
    wait_idle("t2b");
    check("t2_dir_w", dir, 2'b10);
    check("t2_no_pulse", moved_total + bumped_total, p0);

    // Walk west to x=0, then bump against the left edge without a lookup.
    tap(1, 1'b0, 1'b0, mk);
    wait_idle("t3a");
    tap(1, 1'b0, 1'b0, mk);
    wait_idle("t3b");
    r0 = req_rises;
    tap(1, 1'b0, 1'b0, mk);
    wait_idle("t3c");
    check("t3_bump_cycle", last_bump_cyc, mk + 2);
    check("t3_no_req", req_rises, r0);
    check("t3_pos", {x_position, y_position}, {5'd0, 5'd1});

    // Face east, step to (1,1), then hit a wall at (2,1) with ack latency 5.
    tap(4, 1'b0, 1'b0, mk);
    wait_idle("t4a");
    tap(4, 1'b1, 1'b0, mk);
    wait_idle("t4b");
    tap(1, 1'b1, 1'b0, mk);
    wait_idle("t4c");
    wall_map[1][2] = 1'b1;
    ack_lat = 5;
    tap(1, 1'b0, 1'b0, mk);
    wait_idle("t4d");
    check("t4_req_len", last_req_len, ack_lat + 1);
    check("t4_bump_cycle", last_bump_cyc, last_req_cyc + ack_lat + 2);
    check("t4_pos", {x_position, y_position}, {5'd1, 5'd1});
    wall_map[1][2] = 1'b0;
    ack_lat = 0;

    // Hold W: a repeat every RD cycles, typematic duplicates add nothing.
    for (int i = 0; i < 4; i++) model_cmd(1);
    moved_cycs.delete();
    send(8'h1D);
    mk = sent_cyc;
    send_at(mk + 8, 8'h1D);
    send_at(mk + 24, 8'h1D);
    send_at(mk + 40, 8'h1D);
    send_at(mk + 56, 8'hF0);
    send_at(mk + 58, 8'h1D);
    wait_idle("t5");
    repeat (40) @(posedge clock);
    #1;
    check("t5_move_count", moved_cycs.size(), 4);
    for (int i = 0; i < moved_cycs.size() && i < 4; i++)
      check("t5_move_cycle", moved_cycs[i], mk + 4 + RD * i);
    check("t5_pos", {x_position, y_position}, {5'd5, 5'd1});

    // Reset while a lookup is outstanding; a stray ack afterwards is ignored.
    mon_en = 1'b0;
    auto_ack = 1'b0;
    wall_ack = 1'b0;
    send(8'h1D);
    for (int i = 0; i < 20 && wall_req !== 1'b1; i++) begin
      @(posedge clock); #1;
    end
    check("t6_req_seen", wall_req, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("t6_req_dropped", wall_req, 0);
    check("t6_pos", {x_position, y_position}, {5'd1, 5'd1});
    check("t6_dir", dir, 2'b00);
    reset = 1'b0;
    m0 = moved_total;
    wall_ack = 1'b1;
    wall_hit = 1'b0;
    @(posedge clock); #1;
    wall_ack = 1'b0;
    repeat (RD + 8) @(posedge clock);
    #1;
    check("t6_no_move", moved_total, m0);
    check("t6_idle", busy, 0);
    mx = 1; my = 1; mdir = 0;
    exp_q.delete();
    look_q.delete();
    @(posedge clock); #1;
    mon_en = 1'b1;
    auto_ack = 1'b1;

    // Random traffic over a random wall map.
    for (int yy = 0; yy < 20; yy++)
      for (int xx = 0; xx < 20; xx++) wall_map[yy][xx] = ($urandom_range(0, 3) == 0);
    for (int t = 0; t < 60; t++) begin
      ack_lat = $urandom_range(0, 4);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        case ($urandom_range(0, 5))
          0: send(8'h29);
          1: send(8'h75);
          2: begin send(8'hE0); send(8'h1D); end
          3: begin send(8'hF0); send(8'h1C); end
          4: begin send(8'hE0); send(8'hF0); send(8'h72); end
          default: send(8'h5A);
        endcase
      end
      tap($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk);
      wait_idle("rand");
    end
    check("rand_pos", {x_position, y_position, dir}, {5'(mx), 5'(my), 2'(mdir)});
    check("queues_drained", exp_q.size() + look_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
